// File: rtl/mask_pkg.sv
// mask_pkg: shared mask width and dispenser FSM state encoding.
package mask_pkg;
  localparam int MASK_W = 128;
  typedef enum logic [1:0] {SEED_WAIT, DISCARD, RUN, RESEED} state_e;
endpackage

// File: rtl/mask_fifo.sv
// mask_fifo: power-of-two circular buffer holding captured mask words.
module mask_fifo
  import mask_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [MASK_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [MASK_W-1:0]          data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [MASK_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic push, pop;
  assign push = push_i && fill_q != FULL;
  assign pop = pop_i && fill_q != '0;
  assign data_o = mem_q[rd_ptr_q];
  assign valid_o = fill_q != '0;
  assign fill_o = fill_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fill_d = fill_q + FW'(push) - FW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q <= fill_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/mask_dispenser.sv
// mask_dispenser: seeds a PRNG, discards its first word, then buffers words as masks until a reseed is due.
module mask_dispenser
  import mask_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_valid_i,
  input  logic [MASK_W-1:0]          seed_i,
  output logic                       seed_ready_o,
  output logic                       seed_en_o,
  output logic [MASK_W-1:0]          seed_o,
  input  logic [MASK_W-1:0]          prng_data_i,
  output logic                       prng_gen_en_o,
  output logic                       mask_valid_o,
  input  logic                       mask_ready_i,
  output logic [MASK_W-1:0]          mask_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o,
  output logic                       reseed_req_o
);
  localparam int FW = $clog2(DEPTH+1);
  localparam int CW = $clog2(RESEED_INTERVAL+1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [CW-1:0] LIMIT = CW'(RESEED_INTERVAL);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic capture;
  assign seed_ready_o = state_q == SEED_WAIT || state_q == RESEED;
  assign reseed_req_o = seed_ready_o;
  assign seed_en_o = seed_ready_o && seed_valid_i;
  assign seed_o = seed_i;
  // Registered fill only: a same-cycle pop never frees room for a push.
  assign capture = state_q == RUN && fill_o < FULL;
  assign prng_gen_en_o = state_q == DISCARD || capture;
  always_comb begin
    cnt_d = state_q == DISCARD ? '0 : cnt_q + CW'(capture);
    state_d = seed_en_o ? DISCARD :
              state_q == DISCARD ? RUN :
              (capture && cnt_d == LIMIT) ? RESEED : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED_WAIT;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  mask_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (capture),
    .data_i (prng_data_i),
    .pop_i  (mask_ready_i),
    .data_o (mask_o),
    .valid_o(mask_valid_o),
    .fill_o (fill_o)
  );
endmodule

// File: tb/tb_mask_dispenser.sv
// tb_mask_dispenser: xorshift128 PRNG model feeds the DUT; a scoreboard checks delivered masks.
module tb_mask_dispenser;
  logic clk = 0, rst = 1;
  logic seed_valid_i = 0, mask_ready_i = 0;
  logic [127:0] seed_i = '0, prng_q = '0;
  logic seed_ready_o, seed_en_o, prng_gen_en_o, mask_valid_o, reseed_req_o;
  logic [127:0] seed_o, mask_o;
  logic [2:0] fill_o;
  logic [127:0] exp_q[$];
  int tests = 0, fails = 0;

  mask_dispenser #(.DEPTH(4), .RESEED_INTERVAL(8)) dut (
    .clk(clk), .rst(rst), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
    .seed_ready_o(seed_ready_o), .seed_en_o(seed_en_o), .seed_o(seed_o),
    .prng_data_i(prng_q), .prng_gen_en_o(prng_gen_en_o),
    .mask_valid_o(mask_valid_o), .mask_ready_i(mask_ready_i), .mask_o(mask_o),
    .fill_o(fill_o), .reseed_req_o(reseed_req_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] xs(input logic [127:0] s);
    logic [31:0] x, y, z, w, t;
    {x, y, z, w} = s;
    t = x ^ (x << 11);
    return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
  endfunction

  always @(posedge clk)
    if (seed_en_o) prng_q <= seed_o;
    else if (prng_gen_en_o) prng_q <= xs(prng_q);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seed(input logic [127:0] s);
    logic [127:0] v = s;
    for (int k = 1; k <= 8; k++) begin
      v = xs(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_reseed_and_drain(input string tag);
    for (int i = 0; i < 40 && !reseed_req_o; i++) step();
    check({tag, "_reseed_req"}, 128'(reseed_req_o), 128'd1);
    check({tag, "_reseed_gen"}, 128'(prng_gen_en_o), 128'd0);
    for (int i = 0; i < 20 && mask_valid_o; i++) step();
    check({tag, "_drained_valid"}, 128'(mask_valid_o), 128'd0);
    check({tag, "_pending_words"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial forever begin
    @(negedge clk);
    #3;
    if (!rst && mask_valid_o && mask_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mask_unexpected: got %0h expected none", mask_o);
      end else check("mask", mask_o, exp_q.pop_front());
    end
  end

  initial begin
    repeat (3) step();
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_ctl", 128'({mask_valid_o, prng_gen_en_o, seed_ready_o, reseed_req_o}), 128'b0011);
    end
    step();
    seed_valid_i = 1;
    seed_i = 128'h1;
    push_seed(128'h1);
    #1 check("seed_en", 128'(seed_en_o), 128'd1);
    step();
    seed_valid_i = 0;
    #1 check("discard_ctl", 128'({seed_ready_o, prng_gen_en_o, mask_valid_o, reseed_req_o}), 128'b0100);
    check("discard_fill", 128'(fill_o), 128'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("cap_gen", 128'(prng_gen_en_o), 128'd1);
      check("cap_fill", 128'(fill_o), 128'(k));
    end
    step();
    mask_ready_i = 1;
    #1 check("full_gen", 128'(prng_gen_en_o), 128'd0);
    check("full_fill", 128'(fill_o), 128'd4);
    step();
    mask_ready_i = 0;
    #1 check("after_pop_fill", 128'(fill_o), 128'd3);
    check("after_pop_gen", 128'(prng_gen_en_o), 128'd1);
    step();
    check("refill_fill", 128'(fill_o), 128'd4);
    check("refill_gen", 128'(prng_gen_en_o), 128'd0);
    mask_ready_i = 1;
    wait_reseed_and_drain("seed1");
    seed_valid_i = 1;
    seed_i = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    mask_ready_i = 0;
    push_seed(seed_i);
    #1 check("reseed_en", 128'(seed_en_o), 128'd1);
    step();
    seed_valid_i = 0;
    #1 check("rediscard_ctl", 128'({prng_gen_en_o, reseed_req_o}), 128'b10);
    mask_ready_i = 1;
    wait_reseed_and_drain("seed2");
    mask_ready_i = 0;
    seed_valid_i = 1;
    seed_i = 128'h3;
    step();
    seed_valid_i = 0;
    for (int i = 0; i < 20 && fill_o != 3; i++) step();
    check("pre_rst_fill", 128'(fill_o), 128'd3);
    rst = 1;
    step();
    check("rst_fill", 128'(fill_o), 128'd0);
    check("rst_ctl", 128'({mask_valid_o, prng_gen_en_o, seed_ready_o, reseed_req_o}), 128'b0011);
    check("rst_state", 128'(dut.state_q), 128'(mask_pkg::SEED_WAIT));
    rst = 0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mask_dispenser.md
MASK_DISPENSER -- requirements
Module: mask_dispenser

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning mask FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RESEED_INTERVAL, default 1024, meaning PRNG words captured per seed before a reseed is forced (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port seed_valid_i  input  1  seed offered.
REQ-006 SHALL have port seed_i  input  128  seed value.
REQ-007 SHALL have port seed_ready_o  output  1  seed accepted when high with seed_valid_i.
REQ-008 SHALL have port seed_en_o  output  1  PRNG seed-load pulse.
REQ-009 SHALL have port seed_o  output  128  seed to PRNG, combinational copy of seed_i.
REQ-010 SHALL have port prng_data_i  input  128  current PRNG state word.
REQ-011 SHALL have port prng_gen_en_o  output  1  advance PRNG.
REQ-012 SHALL have port mask_valid_o  output  1  mask available.
REQ-013 SHALL have port mask_ready_i  input  1  consumer takes mask.
REQ-014 SHALL have port mask_o  output  128  FIFO head word.
REQ-015 SHALL have port fill_o  output  $clog2(DEPTH+1)  FIFO occupancy.
REQ-016 SHALL have port reseed_req_o  output  1  high in SEED_WAIT and RESEED.

Function
REQ-017 SHALL implement FSM states SEED_WAIT, DISCARD, RUN, RESEED.
REQ-018 SEED_WAIT/RESEED: seed_ready_o=1; on seed_valid_i, seed_en_o=1 same cycle (combinational AND), next state DISCARD.
REQ-019 seed_ready_o SHALL be 0 in DISCARD and RUN; seed_valid_i there is ignored.
REQ-020 DISCARD: prng_gen_en_o=1 for exactly one cycle, no capture, capture counter cleared to 0, next state RUN.
REQ-021 RUN: capture = (fill_o < DEPTH); on capture, prng_gen_en_o=1 and prng_data_i pushed to FIFO in the same cycle.
REQ-022 Capture decision SHALL use registered occupancy only; pop in the same cycle does not enable a push when full.
REQ-023 Each capture SHALL increment the counter; capture reaching RESEED_INTERVAL SHALL move RUN -> RESEED next cycle.
REQ-024 prng_gen_en_o SHALL be 0 in SEED_WAIT and RESEED.
REQ-025 mask_valid_o = (fill_o != 0); mask_o = head word; pop on mask_valid_o && mask_ready_i.
REQ-026 FIFO contents SHALL be retained across RESEED and remain poppable.
REQ-027 Simultaneous push and pop SHALL leave fill_o unchanged and preserve order.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 On rst: state=SEED_WAIT, fill_o=0, pointers=0, counter=0.
REQ-030 Reset outputs: mask_valid_o=0, prng_gen_en_o=0, seed_en_o=0 (unless seed handshake), seed_ready_o=1, reseed_req_o=1.
REQ-031 Reset mid-operation SHALL discard all FIFO contents; mask_o value is don't-care while invalid.

Structure
REQ-032 Package mask_pkg SHALL hold MASK_W=128 and the FSM state enum.
REQ-033 FIFO storage/pointers SHALL be sub-module mask_fifo; FSM and counter in mask_dispenser.

Verification (DEPTH=4, RESEED_INTERVAL=8, reference xorshift128 model driving prng_data_i)
REQ-034 Reset, no seed for 20 cycles -> mask_valid_o=0, prng_gen_en_o=0, seed_ready_o=1, reseed_req_o=1 throughout.
REQ-035 Seed 128'h1 accepted at T, mask_ready_i=0 -> seed_en_o=1 at T; gen_en without capture at T+1; captures T+2..T+5; fill_o=4 and gen_en=0 from T+6.
REQ-036 Then mask_ready_i=1 continuously -> masks back-to-back, equal to model words 1..8 after seed (word 0 discarded), in order.
REQ-037 After 8th capture -> reseed_req_o=1, gen_en=0, residual FIFO words still delivered; new seed -> DISCARD then RUN with counter 0.
REQ-038 fill_o=4 with pop in cycle C -> no capture in C, capture in C+1, fill_o stays 4 at C+2.
REQ-039 rst asserted with fill_o=3 -> next cycle fill_o=0, mask_valid_o=0, state SEED_WAIT.
